video_pll_param_sequencer: RTL and testbench
============================================

Name: video_pll_param_sequencer

Overview:
- Qsys peripheral upstream of the video PLL reconfiguration slave.
- Software writes target divider values n, m and c0 into slave registers, then starts a run.
- The block derives the high, low, bypass and odd counts for each divider and writes the 12 cache entries over an Avalon-MM master.
- It then triggers the reconfiguration and polls busy until the PLL update finishes, so software only ever programs three integers.

Parameters:
- DEFAULT_N, 1, reset value of the N register (must be 1..511).
- DEFAULT_M, 1, reset value of the M register (must be 1..511).
- DEFAULT_C0, 1, reset value of the C0 register (must be 1..511).
- POLL_GAP, 16, idle cycles between busy-poll reads (≥1).
- POLL_LIMIT, 1024, maximum busy-poll reads before a timeout error is flagged.

Ports:
- csi_clk_clock  in  1  sole clock.
- csi_clk_reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  2  slave word address.
- avs_writedata  in  32  slave write data.
- avs_readdata  out  32  slave read data, combinational, zero latency.
- avs_read  in  1  slave read strobe.
- avs_write  in  1  slave write strobe.
- avs_waitrequest  out  1  tied 0.
- avm_address  out  8  master word address: {go, counter_param[2:0], counter_type[3:0]}.
- avm_writedata  out  32  master write data; bits 31:9 always 0.
- avm_readdata  in  32  master read data, valid when avm_read && !avm_waitrequest.
- avm_read  out  1  master read strobe.
- avm_write  out  1  master write strobe.
- avm_waitrequest  in  1  master stall.
- ins_irq_irq  out  1  level interrupt = done && ien.

Behaviour:
- Slave map:
  - 0 = N[8:0], 1 = M[8:0], 2 = C0[8:0]; bits 31:9 read 0.
  - 3 = CTRL. Read: bit0 busy, bit1 done, bit2 err_zero, bit3 err_timeout, bit4 ien.
  - CTRL write: bit0 = start, bit1 = clear done and err bits, bit4 = ien (always written).
- Writes to addresses 0–2 while busy are ignored; values stay stable for the whole run.
- Start is accepted only when idle:
  - Start clears done and both err bits.
  - If any of N, M or C0 is 0: set err_zero and done, do not go busy, emit no master traffic.
  - Start while busy is ignored.
  - If start and clear arrive in the same write, start wins.
- Per divider value v:
  - hi = (v+1)>>1, computed 10-bit, truncated to 9 bits.
  - lo = v − hi.
  - byp = (v == 1).
  - odd = v[0].
- Write sequence, fixed order, 12 writes:
  - counter_param: N = 0, M = 1, C0 = 4.
  - counter_type order within each param: 0 = hi, 1 = lo, 4 = byp, 5 = odd.
  - Resulting addresses: 0x00, 0x01, 0x04, 0x05, 0x10, 0x11, 0x14, 0x15, 0x40, 0x41, 0x44, 0x45.
  - After the 12 writes: one trigger write to 0x80 with data 0.
- Master rules:
  - At most one of avm_read/avm_write is high at a time.
  - Address, data and strobe are held stable while avm_waitrequest is high.
  - A transfer completes on the cycle where the strobe is high and avm_waitrequest is low.
  - Strobes drop for at least 1 cycle between transfers.
- FSM states: IDLE, WR (4-bit index 0..11), TRIG, GAP (counter POLL_GAP), POLL.
  - IDLE → WR on an accepted start.
  - WR → WR with index+1 on each completed write; WR → TRIG after index 11 completes.
  - TRIG → GAP on completion.
  - GAP → POLL when the gap counter expires.
  - POLL, on completion:
    - readdata == 0: → IDLE, set done.
    - otherwise: increment poll count. If count == POLL_LIMIT, set err_timeout and done and go → IDLE; else → GAP.
- busy = (state != IDLE).
- Reset values:
  - State IDLE; all avm_* outputs 0.
  - N/M/C0 = DEFAULT_*.
  - busy, done, err bits and ien all 0; ins_irq_irq 0.
- Reset mid-run: outputs drop asynchronously. The downstream block is in the same reset domain, so no recovery is needed.
- Best-case latency, start write to done (no stalls, busy clears on first poll): 12×2 + 2 + POLL_GAP + 2 cycles.

Decomposition:
- Package video_pll_seq_pkg:
  - FSM state enum.
  - Slave register offsets.
  - Counter-param codes (N = 0, M = 1, C0 = 4) and counter-type codes (0, 1, 4, 5).
  - GO address 8'h80.
  - 12-entry sequence table as a constant function mapping index to {param, type}.
- Sub-module video_pll_count_split: combinational 9-bit v → {hi, lo, byp, odd}, instantiated once and driven by a mux selecting the divider for the current index.

Test Plan:
- N=1, M=10, C0=5, start, slave holds busy for 3 polls → master writes in order:
  - 0x00=1, 0x01=0, 0x04=1, 0x05=1
  - 0x10=5, 0x11=5, 0x14=0, 0x15=0
  - 0x40=3, 0x41=2, 0x44=0, 0x45=1
  - then 0x80, then 4 reads spaced POLL_GAP apart; finally done=1, busy=0.
- M=0, start → no avm activity; CTRL reads 0x06 (done and err_zero set).
- Random avm_waitrequest stalls of 0–5 cycles on every transfer → address/data stable across each stall; same 13-write order as the first scenario.
- Slave never clears busy, POLL_LIMIT=4 → exactly 4 poll reads; done and err_timeout set; ins_irq_irq=1 with ien=1.
- During a run: write N=7 and a second start → N still reads its original value, no second sequence; CTRL write 0x02 after done clears done and irq.
- Assert csi_clk_reset_n low mid-WR → avm strobes 0 that cycle; after release, CTRL reads 0 and N/M/C0 read their defaults.

Source files
------------

// File: rtl/video_pll_seq_pkg.sv
// Shared definitions for the video PLL parameter sequencer: FSM states,
// slave register map, reconfig counter codes and the fixed write order.
package video_pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_TRIG,
    ST_GAP,
    ST_POLL
  } state_t;

  // Slave word offsets
  localparam logic [1:0] REG_N    = 2'd0;
  localparam logic [1:0] REG_M    = 2'd1;
  localparam logic [1:0] REG_C0   = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // Reconfig counter_param codes
  localparam logic [2:0] PARAM_N  = 3'd0;
  localparam logic [2:0] PARAM_M  = 3'd1;
  localparam logic [2:0] PARAM_C0 = 3'd4;

  // Reconfig counter_type codes
  localparam logic [3:0] TYPE_HI  = 4'd0;
  localparam logic [3:0] TYPE_LO  = 4'd1;
  localparam logic [3:0] TYPE_BYP = 4'd4;
  localparam logic [3:0] TYPE_ODD = 4'd5;

  // Trigger address; busy polls are issued to the same word
  localparam logic [7:0] GO_ADDR = 8'h80;

  localparam logic [3:0] SEQ_LAST = 4'd11;

  // Index 0..11 -> {counter_param, counter_type}; four entries per divider
  function automatic logic [6:0] seq_entry(input logic [3:0] idx);
    logic [2:0] p;
    logic [3:0] t;
    case (idx[3:2])
      2'd0:    p = PARAM_N;
      2'd1:    p = PARAM_M;
      default: p = PARAM_C0;
    endcase
    case (idx[1:0])
      2'd0:    t = TYPE_HI;
      2'd1:    t = TYPE_LO;
      2'd2:    t = TYPE_BYP;
      default: t = TYPE_ODD;
    endcase
    return {p, t};
  endfunction

endpackage

// File: rtl/video_pll_count_split.sv
// Splits a divider value into the high/low counts, bypass and odd flags
// expected by the PLL reconfiguration cache.
module video_pll_count_split (
  input  logic [8:0] v,
  output logic [8:0] hi,
  output logic [8:0] lo,
  output logic       byp,
  output logic       odd
);

  logic [9:0] sum;

  // Round-up half computed at 10 bits so v=511 does not wrap before the shift
  assign sum = {1'b0, v} + 10'd1;
  assign hi  = sum[9:1];
  assign lo  = v - hi;
  assign byp = (v == 9'd1);
  assign odd = v[0];

endmodule

// File: rtl/video_pll_param_sequencer.sv
// Software-facing front end for the video PLL reconfig slave: holds N/M/C0,
// writes the 12 derived cache entries, triggers the update and polls busy.
module video_pll_param_sequencer
  import video_pll_seq_pkg::*;
#(
  parameter int unsigned DEFAULT_N  = 1,
  parameter int unsigned DEFAULT_M  = 1,
  parameter int unsigned DEFAULT_C0 = 1,
  parameter int unsigned POLL_GAP   = 16,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic        csi_clk_clock,
  input  logic        csi_clk_reset_n,
  input  logic [1:0]  avs_address,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  input  logic        avs_read,
  input  logic        avs_write,
  output logic        avs_waitrequest,
  output logic [7:0]  avm_address,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic        avm_read,
  output logic        avm_write,
  input  logic        avm_waitrequest,
  output logic        ins_irq_irq
);

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(POLL_GAP - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT);

  state_t        state_reg, state_next;
  logic [3:0]    idx_reg, idx_next;
  logic          active_reg, active_next;
  logic [GW-1:0] gap_reg, gap_next;
  logic [PW-1:0] poll_reg, poll_next;
  logic [8:0]    n_reg, n_next, m_reg, m_next, c0_reg, c0_next;
  logic          done_reg, done_next, err_zero_reg, err_zero_next;
  logic          err_timeout_reg, err_timeout_next, ien_reg, ien_next;

  logic          busy;
  logic [8:0]    div_sel, cnt_hi, cnt_lo, wr_val;
  logic          cnt_byp, cnt_odd;
  logic          unused_bits;

  assign busy            = (state_reg != ST_IDLE);
  assign avs_waitrequest = 1'b0;
  assign ins_irq_irq     = done_reg && ien_reg;
  assign unused_bits     = ^avs_writedata[31:9];

  video_pll_count_split u_split (
    .v   (div_sel),
    .hi  (cnt_hi),
    .lo  (cnt_lo),
    .byp (cnt_byp),
    .odd (cnt_odd)
  );

  // Pick the divider and the derived field addressed by the write index
  always_comb begin
    case (idx_reg[3:2])
      2'd0:    div_sel = n_reg;
      2'd1:    div_sel = m_reg;
      default: div_sel = c0_reg;
    endcase
    case (idx_reg[1:0])
      2'd0:    wr_val = cnt_hi;
      2'd1:    wr_val = cnt_lo;
      2'd2:    wr_val = {8'd0, cnt_byp};
      default: wr_val = {8'd0, cnt_odd};
    endcase
  end

  // State and register file, cleared asynchronously
  always_ff @(posedge csi_clk_clock or negedge csi_clk_reset_n) begin
    if (!csi_clk_reset_n) begin
      state_reg       <= ST_IDLE;
      idx_reg         <= '0;
      active_reg      <= 1'b0;
      gap_reg         <= '0;
      poll_reg        <= '0;
      n_reg           <= 9'(DEFAULT_N);
      m_reg           <= 9'(DEFAULT_M);
      c0_reg          <= 9'(DEFAULT_C0);
      done_reg        <= 1'b0;
      err_zero_reg    <= 1'b0;
      err_timeout_reg <= 1'b0;
      ien_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      active_reg      <= active_next;
      gap_reg         <= gap_next;
      poll_reg        <= poll_next;
      n_reg           <= n_next;
      m_reg           <= m_next;
      c0_reg          <= c0_next;
      done_reg        <= done_next;
      err_zero_reg    <= err_zero_next;
      err_timeout_reg <= err_timeout_next;
      ien_reg         <= ien_next;
    end
  end

  // Slave writes first, then sequencer progress; active_reg marks the strobe
  // cycle so every transfer is preceded by one cycle with strobes low
  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    active_next      = active_reg;
    gap_next         = gap_reg;
    poll_next        = poll_reg;
    n_next           = n_reg;
    m_next           = m_reg;
    c0_next          = c0_reg;
    done_next        = done_reg;
    err_zero_next    = err_zero_reg;
    err_timeout_next = err_timeout_reg;
    ien_next         = ien_reg;

    if (avs_write) begin
      case (avs_address)
        REG_N:  if (!busy) n_next  = avs_writedata[8:0];
        REG_M:  if (!busy) m_next  = avs_writedata[8:0];
        REG_C0: if (!busy) c0_next = avs_writedata[8:0];
        default: begin
          ien_next = avs_writedata[4];
          if (avs_writedata[0] && !busy) begin
            done_next        = 1'b0;
            err_zero_next    = 1'b0;
            err_timeout_next = 1'b0;
            if (n_reg == '0 || m_reg == '0 || c0_reg == '0) begin
              err_zero_next = 1'b1;
              done_next     = 1'b1;
            end else begin
              state_next  = ST_WR;
              idx_next    = '0;
              active_next = 1'b0;
              poll_next   = '0;
            end
          end else if (avs_writedata[1]) begin
            done_next        = 1'b0;
            err_zero_next    = 1'b0;
            err_timeout_next = 1'b0;
          end
        end
      endcase
    end

    case (state_reg)
      ST_WR: begin
        if (!active_reg) begin
          active_next = 1'b1;
        end else if (!avm_waitrequest) begin
          active_next = 1'b0;
          if (idx_reg == SEQ_LAST) state_next = ST_TRIG;
          else                     idx_next   = idx_reg + 4'd1;
        end
      end
      ST_TRIG: begin
        if (!active_reg) begin
          active_next = 1'b1;
        end else if (!avm_waitrequest) begin
          active_next = 1'b0;
          state_next  = ST_GAP;
          gap_next    = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_reg == '0) state_next = ST_POLL;
        else               gap_next   = gap_reg - GW'(1);
      end
      ST_POLL: begin
        if (!active_reg) begin
          active_next = 1'b1;
        end else if (!avm_waitrequest) begin
          active_next = 1'b0;
          if (avm_readdata == 32'd0) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else if (poll_reg + PW'(1) == POLL_LAST) begin
            state_next       = ST_IDLE;
            done_next        = 1'b1;
            err_timeout_next = 1'b1;
          end else begin
            poll_next  = poll_reg + PW'(1);
            state_next = ST_GAP;
            gap_next   = GAP_LOAD;
          end
        end
      end
      default: ;
    endcase
  end

  // Master outputs decoded from registered state only
  always_comb begin
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_address   = 8'h00;
    avm_writedata = 32'd0;
    case (state_reg)
      ST_WR: begin
        avm_write     = active_reg;
        avm_address   = {1'b0, seq_entry(idx_reg)};
        avm_writedata = {23'd0, wr_val};
      end
      ST_TRIG: begin
        avm_write   = active_reg;
        avm_address = GO_ADDR;
      end
      ST_POLL: begin
        avm_read    = active_reg;
        avm_address = GO_ADDR;
      end
      default: ;
    endcase
  end

  // Zero-latency slave read mux
  always_comb begin
    avs_readdata = 32'd0;
    if (avs_read) begin
      case (avs_address)
        REG_N:   avs_readdata = {23'd0, n_reg};
        REG_M:   avs_readdata = {23'd0, m_reg};
        REG_C0:  avs_readdata = {23'd0, c0_reg};
        default: avs_readdata = {27'd0, ien_reg, err_timeout_reg, err_zero_reg,
                                 done_reg, busy};
      endcase
    end
  end

endmodule

// File: tb/tb_video_pll_param_sequencer.sv
// Directed bench for video_pll_param_sequencer with a reconfig-slave model.
module tb_video_pll_param_sequencer;

  localparam int GAP = 4;
  localparam int LIM = 4;
  localparam int DN  = 3;
  localparam int DM  = 6;
  localparam int DC  = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  avs_address = '0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic        avs_waitrequest;
  logic [7:0]  avm_address;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic        avm_read, avm_write;
  logic        avm_waitrequest = 1'b0;
  logic        irq;

  video_pll_param_sequencer #(
    .DEFAULT_N(DN), .DEFAULT_M(DM), .DEFAULT_C0(DC),
    .POLL_GAP(GAP), .POLL_LIMIT(LIM)
  ) dut (
    .csi_clk_clock(clk), .csi_clk_reset_n(rst_n),
    .avs_address(avs_address), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .avs_read(avs_read), .avs_write(avs_write),
    .avs_waitrequest(avs_waitrequest),
    .avm_address(avm_address), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_read(avm_read), .avm_write(avm_write),
    .avm_waitrequest(avm_waitrequest), .ins_irq_irq(irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reconfig slave model state
  logic [7:0]  wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          rd_cyc  [0:63];
  int          wr_cnt = 0, rd_cnt = 0;
  int          busy_left = 0;
  bit          never_clear = 0, stall_mode = 0;
  int          stall_left = 0;
  bit          in_xfer = 0, prev_stall = 0, last_done = 0;
  logic [7:0]  p_addr;
  logic [31:0] p_data;
  logic        p_rd, p_wr;

  // Slave model: stalls, logs completed transfers and checks master rules
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0; in_xfer = 0; last_done = 0; avm_waitrequest = 1'b0;
    end else begin
      if (prev_stall) begin
        tests++;
        if (avm_address !== p_addr || avm_writedata !== p_data ||
            avm_read !== p_rd || avm_write !== p_wr) begin
          fails++;
          $display("FAIL stall_hold: got a=%h d=%h r=%b w=%b required a=%h d=%h r=%b w=%b",
                   avm_address, avm_writedata, avm_read, avm_write, p_addr, p_data, p_rd, p_wr);
        end
      end
      if (last_done) begin
        tests++;
        if (avm_read || avm_write) begin
          fails++;
          $display("FAIL strobe_gap: got r=%b w=%b after completion, required 0 0", avm_read, avm_write);
        end
      end
      last_done = 0;
      avm_readdata = 32'hDEAD_BEEF;
      if (avm_read || avm_write) begin
        tests++;
        if (avm_read && avm_write) begin
          fails++;
          $display("FAIL one_strobe: got r=1 w=1 required at most one");
        end
        if (!in_xfer) begin
          in_xfer = 1;
          stall_left = stall_mode ? int'($urandom_range(0, 5)) : 0;
        end
        if (stall_left > 0) begin
          stall_left--;
          avm_waitrequest = 1'b1;
          prev_stall = 1;
          p_addr = avm_address; p_data = avm_writedata; p_rd = avm_read; p_wr = avm_write;
        end else begin
          avm_waitrequest = 1'b0;
          prev_stall = 0; in_xfer = 0; last_done = 1;
          if (avm_write) begin
            if (wr_cnt < 64) begin wr_addr[wr_cnt] = avm_address; wr_data[wr_cnt] = avm_writedata; end
            wr_cnt++;
          end else begin
            if (rd_cnt < 64) rd_cyc[rd_cnt] = cyc;
            rd_cnt++;
            avm_readdata = (never_clear || busy_left > 0) ? 32'h1 : 32'h0;
            if (busy_left > 0) busy_left--;
          end
        end
      end else begin
        avm_waitrequest = 1'b0; prev_stall = 0; in_xfer = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  int start_cyc, idle_cyc;

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
    start_cyc = cyc;
    $display("[TB] cyc %0d slave write addr %0d data 0x%0h", cyc, a, d);
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    #1 d = avs_readdata;
    avs_read = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    bit ok;
    ok = 0;
    avs_address = 2'd3; avs_read = 1'b1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      #1;
      if (avs_readdata[0] == 1'b0) begin ok = 1; break; end
    end
    avs_read = 1'b0;
    idle_cyc = cyc;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL idle_timeout: got busy after %0d cycles required idle", max);
    end
  endtask

  task automatic start_run(input logic [8:0] n, input logic [8:0] m, input logic [8:0] c0,
                           input int polls, input bit stall, input bit nc);
    busy_left = polls; never_clear = nc; stall_mode = stall;
    cpu_write(2'd0, {23'd0, n});
    cpu_write(2'd1, {23'd0, m});
    cpu_write(2'd2, {23'd0, c0});
    wr_cnt = 0; rd_cnt = 0;
    cpu_write(2'd3, 32'h11);
  endtask

  typedef struct packed {
    logic [8:0]        n, m, c0;
    logic [3:0]        polls;
    logic              stall;
    logic [0:11][8:0]  exp;
  } vec_t;

  vec_t vecs [0:3];
  logic [0:12][7:0] exp_addr;
  logic [31:0] rd;

  initial begin
    exp_addr = {8'h00, 8'h01, 8'h04, 8'h05, 8'h10, 8'h11, 8'h14, 8'h15,
                8'h40, 8'h41, 8'h44, 8'h45, 8'h80};
    vecs[0] = '{n: 9'd1, m: 9'd10, c0: 9'd5, polls: 4'd3, stall: 1'b0,
                exp: {9'd1, 9'd0, 9'd1, 9'd1, 9'd5, 9'd5, 9'd0, 9'd0, 9'd3, 9'd2, 9'd0, 9'd1}};
    vecs[1] = '{n: 9'd1, m: 9'd10, c0: 9'd5, polls: 4'd3, stall: 1'b1,
                exp: {9'd1, 9'd0, 9'd1, 9'd1, 9'd5, 9'd5, 9'd0, 9'd0, 9'd3, 9'd2, 9'd0, 9'd1}};
    vecs[2] = '{n: 9'd2, m: 9'd511, c0: 9'd3, polls: 4'd0, stall: 1'b0,
                exp: {9'd1, 9'd1, 9'd0, 9'd0, 9'd256, 9'd255, 9'd0, 9'd1, 9'd2, 9'd1, 9'd0, 9'd1}};
    vecs[3] = '{n: 9'd9, m: 9'd1, c0: 9'd4, polls: 4'd1, stall: 1'b1,
                exp: {9'd5, 9'd4, 9'd0, 9'd1, 9'd1, 9'd0, 9'd1, 9'd1, 9'd2, 9'd2, 9'd0, 9'd0}};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_avm_write", {31'd0, avm_write}, 32'd0);
    check("rst_avm_read", {31'd0, avm_read}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    cpu_read(2'd3, rd); check("rst_ctrl", rd, 32'h0);
    cpu_read(2'd0, rd); check("rst_n_reg", rd, DN);
    cpu_read(2'd1, rd); check("rst_m_reg", rd, DM);
    cpu_read(2'd2, rd); check("rst_c0_reg", rd, DC);
    check("waitrequest", {31'd0, avs_waitrequest}, 32'd0);

    // Full sequences from the vector table
    for (int v = 0; v < 4; v++) begin
      start_run(vecs[v].n, vecs[v].m, vecs[v].c0, int'(vecs[v].polls), vecs[v].stall, 1'b0);
      wait_idle(1000);
      $display("[TB] vec %0d: n=%0d m=%0d c0=%0d writes=%0d reads=%0d",
               v, vecs[v].n, vecs[v].m, vecs[v].c0, wr_cnt, rd_cnt);
      check("wr_count", wr_cnt, 13);
      for (int i = 0; i < 13 && i < wr_cnt; i++) begin
        check($sformatf("v%0d_addr%0d", v, i), {24'd0, wr_addr[i]}, {24'd0, exp_addr[i]});
        check($sformatf("v%0d_data%0d", v, i), wr_data[i],
              (i < 12) ? {23'd0, vecs[v].exp[i]} : 32'd0);
      end
      check("rd_count", rd_cnt, int'(vecs[v].polls) + 1);
      if (!vecs[v].stall) begin
        for (int i = 1; i < rd_cnt && i < 64; i++) begin
          tests++;
          if (rd_cyc[i] - rd_cyc[i-1] < GAP + 1) begin
            fails++;
            $display("FAIL poll_gap: got spacing %0d required >= %0d", rd_cyc[i] - rd_cyc[i-1], GAP + 1);
          end
        end
      end
      if (vecs[v].polls == 0 && !vecs[v].stall)
        check("latency", idle_cyc - start_cyc, 12 * 2 + 2 + GAP + 2);
      cpu_read(2'd3, rd); check("ctrl_done", rd, 32'h12);
      check("irq_done", {31'd0, irq}, 32'd1);
    end

    // Zero divider: error, no master traffic
    cpu_write(2'd1, 32'd0);
    wr_cnt = 0; rd_cnt = 0;
    cpu_write(2'd3, 32'h01);
    repeat (10) @(negedge clk);
    check("zero_writes", wr_cnt, 0);
    check("zero_reads", rd_cnt, 0);
    cpu_read(2'd3, rd); check("zero_ctrl", rd, 32'h06);
    check("zero_irq", {31'd0, irq}, 32'd0);

    // Busy never clears: timeout after POLL_LIMIT reads
    start_run(9'd4, 9'd4, 9'd4, 0, 1'b0, 1'b1);
    wait_idle(1000);
    $display("[TB] timeout run: writes=%0d reads=%0d", wr_cnt, rd_cnt);
    check("to_reads", rd_cnt, LIM);
    check("to_writes", wr_cnt, 13);
    cpu_read(2'd3, rd); check("to_ctrl", rd, 32'h1A);
    check("to_irq", {31'd0, irq}, 32'd1);

    // Writes while busy are ignored, second start ignored
    start_run(9'd5, 9'd8, 9'd2, 3, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    cpu_write(2'd0, 32'd7);
    cpu_write(2'd3, 32'h11);
    wait_idle(1000);
    $display("[TB] busy-write run: writes=%0d reads=%0d", wr_cnt, rd_cnt);
    cpu_read(2'd0, rd); check("busy_n_kept", rd, 32'd5);
    check("busy_writes", wr_cnt, 13);
    check("busy_reads", rd_cnt, 4);
    cpu_read(2'd3, rd); check("busy_ctrl", rd, 32'h12);
    cpu_write(2'd3, 32'h12);
    cpu_read(2'd3, rd); check("clear_ctrl", rd, 32'h10);
    check("clear_irq", {31'd0, irq}, 32'd0);

    // Start and clear together: start wins
    busy_left = 0; never_clear = 0;
    cpu_write(2'd3, 32'h13);
    #1 cpu_read(2'd3, rd); check("start_wins", rd, 32'h11);
    wait_idle(1000);

    // Reset in the middle of the write phase
    start_run(9'd3, 9'd3, 9'd3, 0, 1'b0, 1'b0);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (avm_write && wr_cnt < 12) begin seen = 1; break; end
      end
      check("mid_wr_seen", {31'd0, seen}, 32'd1);
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid_write", {31'd0, avm_write}, 32'd0);
    check("rst_mid_read", {31'd0, avm_read}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cpu_read(2'd3, rd); check("rst2_ctrl", rd, 32'h0);
    cpu_read(2'd0, rd); check("rst2_n", rd, DN);
    cpu_read(2'd1, rd); check("rst2_m", rd, DM);
    cpu_read(2'd2, rd); check("rst2_c0", rd, DC);
    repeat (3) @(negedge clk);
    check("rst2_idle_write", {31'd0, avm_write}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
